// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator command sequencer.
//   - key code constants as produced by the keypad front end
//   - calculator core status encoding
//   - sequencer state encoding
//   - key_class(): sorts a key code into digit / operator / equals / backspace
package calc_pkg;

  localparam int KEY_W = 4;

  localparam logic [KEY_W-1:0] MAX_DIGIT   = 4'd9;
  localparam logic [KEY_W-1:0] KEY_ADD     = 4'b1010;
  localparam logic [KEY_W-1:0] KEY_SUB     = 4'b1011;
  localparam logic [KEY_W-1:0] KEY_MUL     = 4'b1100;
  localparam logic [KEY_W-1:0] KEY_OP_RSVD = 4'b1101;
  localparam logic [KEY_W-1:0] KEY_EQ      = 4'b1110;
  localparam logic [KEY_W-1:0] KEY_BKSP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_ERR   = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_IDLE  = 2'b11
  } calc_status_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OP_HOLD  = 2'd1,
    WAIT_RES = 2'd2,
    ERR      = 2'd3
  } calc_seq_state_t;

  typedef enum logic [1:0] {
    KC_DIGIT,
    KC_OP,
    KC_EQ,
    KC_BKSP
  } key_class_t;

  function automatic key_class_t key_class(input logic [KEY_W-1:0] code);
    key_class_t kc;
    if (code <= MAX_DIGIT) begin
      kc = KC_DIGIT;
    end else begin
      case (code)
        KEY_ADD, KEY_SUB, KEY_MUL, KEY_OP_RSVD: kc = KC_OP;
        KEY_EQ:                                 kc = KC_EQ;
        KEY_BKSP:                               kc = KC_BKSP;
        default:                                kc = KC_DIGIT;
      endcase
    end
    return kc;
  endfunction

endpackage

// File: rtl/calc_seq_cmd_fifo.sv
// cmd_fifo: DEPTH x W synchronous FIFO with show-ahead head output.
//   clock, reset : shared system clock / synchronous active-high reset
//   flush        : synchronous clear of occupancy (contents are don't-care)
//   push, din    : write request; ignored while full
//   pop          : read request; ignored while empty
//   dout         : current head word (valid while !empty)
//   full, empty  : occupancy flags
//   count        : occupancy, 0..DEPTH
// A word written into an empty FIFO only becomes visible at dout after the
// write edge, so there is no write-through path from din to dout.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_seq.sv
// calc_seq: command sequencer between keypad front end and calculator core.
// Accepted key codes are queued in cmd_fifo and issued one per cycle on the
// core command port. Operators are strobed for two cycles, equals waits for
// the core result under a timeout, and any core error or timeout latches a
// sticky err that only reset clears.
//   clock, reset          : system clock, synchronous active-high reset
//   key_valid, key_code   : key offer from the front end
//   key_ready             : FIFO can accept (registers only, not key_valid)
//   calc_status           : core status (00 err, 01 busy, 10 ready, 11 idle)
//   calc_en, calc_cmd     : registered command strobe and code to the core
//   err                   : sticky error flag
//   fifo_count            : current FIFO occupancy
import calc_pkg::*;

module calc_seq #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [KEY_W-1:0]         key_code,
  output logic                     key_ready,
  input  logic [1:0]               calc_status,
  output logic                     calc_en,
  output logic [KEY_W-1:0]         calc_cmd,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  calc_seq_state_t  state;
  calc_seq_state_t  state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             en_nxt;
  logic [KEY_W-1:0] cmd_nxt;
  logic             err_nxt;

  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [KEY_W-1:0] head;

  assign key_ready = !full && (state != ERR);
  assign push      = key_valid && key_ready;
  // Flushing during every ERR cycle empties the FIFO one cycle after entry.
  assign flush     = (state == ERR);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   (key_code),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_nxt    = 1'b0;
    cmd_nxt   = calc_cmd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (calc_status == ST_ERR) begin
          state_nxt = ERR;
        end else if (!empty && (calc_status != ST_BUSY)) begin
          pop     = 1'b1;
          en_nxt  = 1'b1;
          cmd_nxt = head;
          case (key_class(head))
            KC_OP: state_nxt = OP_HOLD;
            KC_EQ: begin
              state_nxt = WAIT_RES;
              cnt_nxt   = '0;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      OP_HOLD: begin
        // Busy is ignored here: only the pop cycle checks it.
        if (calc_status == ST_ERR) begin
          state_nxt = ERR;
        end else begin
          en_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RES: begin
        cnt_nxt = cnt + CNT_ONE;
        if (calc_status == ST_READY) begin
          state_nxt = IDLE;
        end else if ((calc_status == ST_ERR) || (cnt == CNT_LAST)) begin
          state_nxt = ERR;
        end
      end
      default: state_nxt = ERR;
    endcase
    err_nxt = err || (state_nxt == ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      calc_en  <= 1'b0;
      calc_cmd <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      calc_en  <= en_nxt;
      calc_cmd <= cmd_nxt;
      err      <= err_nxt;
    end
  end

endmodule
